output_pair_serializer: RTL and testbench
=========================================

OUTPUT_PAIR_SERIALIZER -- requirements
Module: output_pair_serializer

Interface
REQ-001 SHALL take parameter word_size, default 16: width of one output FIFO token.
REQ-002 SHALL take parameter depth, default 4: number of queued result/status pairs (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_in, input, 1 bit: single-cycle push strobe from the firing-state FSM (its en_wr_output_fifo).
REQ-006 SHALL have port result_in, input, 2*word_size bits: result word captured on push.
REQ-007 SHALL have port status_in, input, 2*word_size bits: status word captured on push.
REQ-008 SHALL have port free_result, input, word_size bits: free slots in the downstream result FIFO.
REQ-009 SHALL have port free_status, input, word_size bits: free slots in the downstream status FIFO.
REQ-010 SHALL have port wr_out_result, output, 1 bit: result FIFO write enable.
REQ-011 SHALL have port wr_out_status, output, 1 bit: status FIFO write enable.
REQ-012 SHALL have port data_out_result, output, word_size bits: token to the result FIFO.
REQ-013 SHALL have port data_out_status, output, word_size bits: token to the status FIFO.
REQ-014 SHALL have port count, output, log2(depth)+1 bits: number of queued pairs.
REQ-015 SHALL have port full, output, 1 bit: high when count == depth.
REQ-016 SHALL have port empty, output, 1 bit: high when count == 0.
REQ-017 SHALL have port drop_err, output, 1 bit: sticky flag, set when a push is lost.

Function
REQ-018 SHALL hold the queue as a circular buffer of depth entries, each {status_in, result_in}, with wrapping read and write pointers.
REQ-019 SHALL, when wr_in=1 and full=0 in a cycle, write the entry at the write pointer and advance that pointer at the clock edge.
REQ-020 SHALL, when wr_in=1 and full=1, discard the push, leave all queue contents unchanged, and set drop_err; a pop in the same cycle does not make room for that push.
REQ-021 SHALL use FSM states IDLE, SEND_LO and SEND_HI.
REQ-022 SHALL, in IDLE, move to SEND_LO when count>0, free_result>=2 and free_status>=2; otherwise it SHALL stay in IDLE.
REQ-023 SHALL, in SEND_LO, assert wr_out_result and wr_out_status with data_out_result=head.result[word_size-1:0] and data_out_status=head.status[word_size-1:0], then go to SEND_HI unconditionally.
REQ-024 SHALL, in SEND_HI, assert both write enables with the upper halves [2*word_size-1:word_size], pop the head (advance the read pointer) at the clock edge, and return to IDLE.
REQ-025 SHALL decode write enables from the state register only; data outputs SHALL be 0 whenever the write enables are low.
REQ-026 SHALL update count by +1 on push only, -1 on pop only, and 0 on a simultaneous push and pop.
REQ-027 SHALL meet this latency: push accepted in cycle 0 into an empty queue, with free space available, gives SEND_LO in cycle 2 and SEND_HI in cycle 3; sustained throughput is one pair per 3 cycles.
REQ-028 SHALL not re-check free space in SEND_HI; the >=2 check in IDLE guarantees room for both halves.
REQ-029 SHALL clear drop_err only by rst.

Reset
REQ-030 SHALL, while rst=1, asynchronously force state=IDLE, both pointers=0, count=0, empty=1, full=0, drop_err=0, and all write enables and data outputs to 0.
REQ-031 SHALL accept that a reset asserted in SEND_HI leaves only the low halves written downstream; the queued pair is discarded and no recovery is attempted.
REQ-032 SHALL not require storage contents to be reset; only pointers and count are reset.

Verification
REQ-033 Single pair: push result_in=32'h1234_ABCD, status_in=32'h0000_0001, free=8 -> cycle 2: data_out_result=16'hABCD, data_out_status=16'h0001, both enables high; cycle 3: 16'h1234 / 16'h0000; count returns to 0.
REQ-034 Backpressure: push one pair with free_result=1 for 10 cycles -> no write enables, count=1; set free_result=2 -> SEND_LO follows in the next cycle.
REQ-035 Overflow: free=0, push 5 pairs (depth=4) -> full=1 after the 4th push, 5th discarded, drop_err=1; release free=8 -> exactly 4 pairs emitted in push order.
REQ-036 Wrap and simultaneous: continuous pushes of 6 pairs every 3 cycles with free=8 -> all 6 emitted in order, pointers wrap, count never exceeds 2, and push/pop coinciding in SEND_HI leaves count unchanged.
REQ-037 Reset mid-operation: assert rst during SEND_HI with 2 pairs queued -> enables drop the same cycle, count=0, empty=1; after release, no further writes until a new push.

Source files
------------

// File: rtl/output_pair_serializer.sv
// Queues {status, result} double-word pairs and streams each pair as low then
// high halves into the downstream result/status FIFOs, once both have room for two tokens.
module output_pair_serializer #(
  parameter int word_size = 16,
  parameter int depth     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_in,
  input  logic [2*word_size-1:0]     result_in,
  input  logic [2*word_size-1:0]     status_in,
  input  logic [word_size-1:0]       free_result,
  input  logic [word_size-1:0]       free_status,
  output logic                       wr_out_result,
  output logic                       wr_out_status,
  output logic [word_size-1:0]       data_out_result,
  output logic [word_size-1:0]       data_out_status,
  output logic [$clog2(depth):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop_err,
  output logic [1:0]                 state_dbg
);

  localparam int addr_w = $clog2(depth);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  // Handshake: wr_in is a one-cycle push strobe with no ready; a push while
  // full is lost and latched in drop_err. wr_out_* are one-cycle write
  // strobes whose room was guaranteed by the free_* >= 2 check taken in IDLE.
  state_t state, state_next;

  logic [4*word_size-1:0] mem [depth];
  logic [4*word_size-1:0] head;
  logic [addr_w-1:0]      wr_ptr, rd_ptr;
  logic                   push, pop, room;

  assign full   = (count == (addr_w+1)'(depth));
  assign empty  = (count == '0);
  assign push   = wr_in && !full;
  assign pop    = (state == SEND_HI);
  assign head   = mem[rd_ptr];
  assign room   = (free_result >= word_size'(2)) && (free_status >= word_size'(2));
  assign state_dbg = state;

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {status_in, result_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
      state    <= IDLE;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_in && full) drop_err <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next      = state;
    wr_out_result   = 1'b0;
    wr_out_status   = 1'b0;
    data_out_result = '0;
    data_out_status = '0;
    case (state)
      IDLE: begin
        if (!empty && room) state_next = SEND_LO;
      end
      SEND_LO: begin
        wr_out_result   = 1'b1;
        wr_out_status   = 1'b1;
        data_out_result = head[word_size-1:0];
        data_out_status = head[2*word_size +: word_size];
        state_next      = SEND_HI;
      end
      SEND_HI: begin
        wr_out_result   = 1'b1;
        wr_out_status   = 1'b1;
        data_out_result = head[word_size +: word_size];
        data_out_status = head[3*word_size +: word_size];
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_output_pair_serializer.sv
// Bench for output_pair_serializer: queue-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_output_pair_serializer;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_in;
  logic [2*W-1:0] result_in, status_in;
  logic [W-1:0]  free_result, free_status;
  logic          wr_out_result, wr_out_status;
  logic [W-1:0]  data_out_result, data_out_status;
  logic [2:0]    count;
  logic          full, empty, drop_err;
  logic [1:0]    state_dbg;

  output_pair_serializer #(.word_size(W), .depth(D)) dut (
    .clk(clk), .rst(rst), .wr_in(wr_in), .result_in(result_in), .status_in(status_in),
    .free_result(free_result), .free_status(free_status),
    .wr_out_result(wr_out_result), .wr_out_status(wr_out_status),
    .data_out_result(data_out_result), .data_out_status(data_out_status),
    .count(count), .full(full), .empty(empty), .drop_err(drop_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  // exp_q holds accepted pairs as {status, result}; phase is the next half
  // the downstream must see: 0 none, 1 low half, 2 high half.
  logic [63:0] exp_q[$];
  int m_count = 0;
  int phase = 0;
  bit m_drop = 1'b0;
  int pairs_out = 0;
  int writes_seen = 0;

  always @(negedge clk) begin
    logic [63:0] e;
    logic [W-1:0] er, es;
    int nphase;
    if (rst) begin
      check("rst_wr_res", wr_out_result, 0);
      check("rst_wr_sta", wr_out_status, 0);
      check("rst_data", {data_out_result, data_out_status}, 0);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_drop", drop_err, 0);
      exp_q.delete();
      m_count = 0;
      phase   = 0;
      m_drop  = 1'b0;
    end else begin
      e  = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
      er = '0;
      es = '0;
      if (phase == 1) begin er = e[15:0];  es = e[47:32]; end
      if (phase == 2) begin er = e[31:16]; es = e[63:48]; end
      check("m_wr_res", wr_out_result, phase != 0);
      check("m_wr_sta", wr_out_status, phase != 0);
      check("m_data_res", data_out_result, er);
      check("m_data_sta", data_out_status, es);
      check("m_count", count, m_count);
      check("m_full", full, m_count == D);
      check("m_empty", empty, m_count == 0);
      check("m_drop", drop_err, m_drop);
      if (wr_out_result) writes_seen++;
      // next-cycle expectation
      if (phase == 1)      nphase = 2;
      else if (phase == 2) nphase = 0;
      else nphase = (m_count > 0 && free_result >= 2 && free_status >= 2) ? 1 : 0;
      if (wr_in) begin
        if (m_count == D) m_drop = 1'b1;
        else begin
          exp_q.push_back({status_in, result_in});
          m_count++;
        end
      end
      if (phase == 2) begin
        void'(exp_q.pop_front());
        m_count--;
        pairs_out++;
      end
      phase = nphase;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic [31:0] s);
    wr_in = 1'b1;
    result_in = r;
    status_in = s;
    tick();
    wr_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int max_cnt;
    rst = 1'b1;
    wr_in = 1'b0;
    result_in = '0;
    status_in = '0;
    free_result = 16'd8;
    free_status = 16'd8;
    repeat (3) tick();
    check("reset_state", state_dbg, 0);
    rst = 1'b0;
    tick();

    // single pair: low halves in cycle 2, high halves in cycle 3
    push(32'h1234_ABCD, 32'h0000_0001);
    check("single_c1_idle", wr_out_result, 0);
    check("single_c1_count", count, 1);
    tick();
    check("single_lo_en", {wr_out_result, wr_out_status}, 2'b11);
    check("single_lo_res", data_out_result, 16'hABCD);
    check("single_lo_sta", data_out_status, 16'h0001);
    tick();
    check("single_hi_en", {wr_out_result, wr_out_status}, 2'b11);
    check("single_hi_res", data_out_result, 16'h1234);
    check("single_hi_sta", data_out_status, 16'h0000);
    tick();
    check("single_done_count", count, 0);
    check("single_done_en", wr_out_result, 0);
    repeat (2) tick();

    // backpressure: one free result slot holds the pair in IDLE
    free_result = 16'd1;
    push(32'hCAFE_0102, 32'h5555_7777);
    base = writes_seen;
    repeat (10) tick();
    check("bp_no_writes", writes_seen - base, 0);
    check("bp_count", count, 1);
    free_result = 16'd2;
    tick();
    check("bp_lo_en", wr_out_result, 1);
    check("bp_lo_res", data_out_result, 16'h0102);
    check("bp_lo_sta", data_out_status, 16'h7777);
    repeat (3) tick();
    free_result = 16'd8;

    // overflow: five pushes into depth four with no room downstream
    free_result = 16'd0;
    free_status = 16'd0;
    for (int i = 0; i < 5; i++) begin
      wr_in = 1'b1;
      result_in = 32'hA000_0000 + 32'(i);
      status_in = 32'h5000_0010 + 32'(i);
      tick();
      if (i == 3) check("ovf_full_after4", full, 1);
      if (i == 3) check("ovf_drop_before5", drop_err, 0);
    end
    wr_in = 1'b0;
    check("ovf_drop", drop_err, 1);
    check("ovf_count", count, 4);
    free_result = 16'd8;
    free_status = 16'd8;
    base = pairs_out;
    repeat (16) tick();
    check("ovf_pairs_out", pairs_out - base, 4);
    check("ovf_drained", count, 0);
    check("ovf_drop_sticky", drop_err, 1);

    // wrap and push/pop coincidence: a push every 3 cycles
    base = pairs_out;
    max_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      push(32'h0BAD_0000 + 32'(i * 17), 32'h00F0_0000 + 32'(i * 3));
      check("wrap_count_after_push", count, 1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      repeat (2) begin
        tick();
        if (int'(count) > max_cnt) max_cnt = int'(count);
      end
    end
    repeat (6) tick();
    check("wrap_pairs_out", pairs_out - base, 6);
    check("wrap_max_count", max_cnt, 1);
    check("wrap_drained", count, 0);

    // reset during SEND_HI with two pairs queued
    wr_in = 1'b1;
    result_in = 32'h1111_2222;
    status_in = 32'h3333_4444;
    tick();
    result_in = 32'h5555_6666;
    status_in = 32'h7777_8888;
    tick();
    wr_in = 1'b0;
    check("rmid_lo_res", data_out_result, 16'h2222);
    tick();
    check("rmid_hi_res", data_out_result, 16'h1111);
    check("rmid_count_before", count, 2);
    rst = 1'b1;
    #1;
    check("rmid_en_drop", {wr_out_result, wr_out_status}, 2'b00);
    check("rmid_count", count, 0);
    check("rmid_empty", empty, 1);
    check("rmid_drop_clr", drop_err, 0);
    tick();
    rst = 1'b0;
    base = writes_seen;
    repeat (10) tick();
    check("rmid_quiet", writes_seen - base, 0);
    base = pairs_out;
    push(32'h9876_5432, 32'h0F0F_F0F0);
    repeat (5) tick();
    check("rmid_new_pair", pairs_out - base, 1);
    check("rmid_final_count", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
